traffic_light_ctrl_p: RTL and testbench

- Parametrised successor to the team's fixed two-way intersection controller (NS/EW heads).
- Adds per-direction configurable green, yellow and all-red durations, a clock prescaler (tick), a latched pedestrian request with an all-red WALK phase, and a night flashing-yellow mode.
- Sits between the board clock/reset and the lamp drivers. Lamp encoding is unchanged: red=3'b100, yellow=3'b010, green=3'b001, dark=3'b000.

---
 rtl/traffic_light_ctrl_p.sv | 175 +++++++++++++++++
 tb/tb_traffic_light_ctrl_p.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_p.sv
// Two-way intersection controller with configurable phase lengths, a tick
// prescaler, a latched pedestrian request served in an all-red WALK phase,
// and a night-time flashing-yellow mode. Lamps are {red,yellow,green}.
module traffic_light_ctrl_p #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned GREEN_NS   = 50,
  parameter int unsigned GREEN_EW   = 50,
  parameter int unsigned YELLOW     = 10,
  parameter int unsigned ALL_RED    = 2,
  parameter int unsigned WALK       = 20,
  parameter int unsigned FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] NS_light,
  output logic [2:0] EW_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  localparam logic [CNT_W-1:0] TICK_M1     = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_NS_M1 = CNT_W'(GREEN_NS - 1);
  localparam logic [CNT_W-1:0] GREEN_EW_M1 = CNT_W'(GREEN_EW - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] ALL_RED_M1  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_M1     = CNT_W'(WALK - 1);
  localparam logic [CNT_W-1:0] FLASH_M1    = CNT_W'(FLASH_HALF - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] dur_m1;
  logic             flash_on_q, flash_on_d;
  logic             ped_q, ped_d;
  logic             tick;
  logic [2:0]       ns_q, ew_q;
  logic             walk_q;

  // Lamp pattern for a given state; flash phase only matters in FLASH.
  function automatic logic [6:0] lamp_decode(input state_t s, input logic on);
    logic [6:0] r;
    r = {LAMP_RED, LAMP_RED, 1'b0};
    case (s)
      NS_GREEN:  r = {LAMP_GREEN,  LAMP_RED,    1'b0};
      NS_YELLOW: r = {LAMP_YELLOW, LAMP_RED,    1'b0};
      EW_GREEN:  r = {LAMP_RED,    LAMP_GREEN,  1'b0};
      EW_YELLOW: r = {LAMP_RED,    LAMP_YELLOW, 1'b0};
      PED_WALK:  r = {LAMP_RED,    LAMP_RED,    1'b1};
      FLASH:     r = on ? {LAMP_YELLOW, LAMP_YELLOW, 1'b0}
                        : {LAMP_DARK,   LAMP_DARK,   1'b0};
      default:   r = {LAMP_RED,    LAMP_RED,    1'b0};
    endcase
    return r;
  endfunction

  // Tick fires on the prescaler wrap cycle, so every cycle when TICK_DIV=1.
  always_comb begin
    tick = (presc_q == TICK_M1);
  end

  // Free-running prescaler that wraps at TICK_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + CNT_W'(1);
  end

  // Duration of the current state in ticks, minus one.
  always_comb begin
    dur_m1 = GREEN_NS_M1;
    case (state_q)
      NS_GREEN:             dur_m1 = GREEN_NS_M1;
      NS_YELLOW, EW_YELLOW: dur_m1 = YELLOW_M1;
      ALL_RED_1, ALL_RED_2: dur_m1 = ALL_RED_M1;
      EW_GREEN:             dur_m1 = GREEN_EW_M1;
      PED_WALK:             dur_m1 = WALK_M1;
      FLASH:                dur_m1 = FLASH_M1;
      default:              dur_m1 = GREEN_NS_M1;
    endcase
  end

  // Next-state, timer, flash phase and pedestrian latch; flash_mode and the
  // latched request are only consulted at the end of a clearance or off-phase.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    flash_on_d = flash_on_q;
    if (tick) begin
      if (timer_q == dur_m1) begin
        timer_d = '0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_1;
          ALL_RED_1: begin
            if (flash_mode) begin
              state_d    = FLASH;
              flash_on_d = 1'b1;
            end else begin
              state_d = EW_GREEN;
            end
          end
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_2;
          ALL_RED_2: begin
            if (flash_mode) begin
              state_d    = FLASH;
              flash_on_d = 1'b1;
            end else if (ped_q) begin
              state_d = PED_WALK;
            end else begin
              state_d = NS_GREEN;
            end
          end
          PED_WALK:  state_d = NS_GREEN;
          FLASH: begin
            if (flash_on_q)      flash_on_d = 1'b0;
            else if (flash_mode) flash_on_d = 1'b1;
            else                 state_d    = ALL_RED_2;
          end
          default:   state_d = NS_GREEN;
        endcase
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end
    if (state_d == PED_WALK && state_q != PED_WALK) ped_d = 1'b0;
    else if (state_q != PED_WALK && ped_req)        ped_d = 1'b1;
    else                                            ped_d = ped_q;
  end

  // Controller state and lamp registers, lamps loaded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= NS_GREEN;
      timer_q    <= '0;
      flash_on_q <= 1'b0;
      ped_q      <= 1'b0;
      ns_q       <= LAMP_GREEN;
      ew_q       <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      flash_on_q <= flash_on_d;
      ped_q      <= ped_d;
      {ns_q, ew_q, walk_q} <= lamp_decode(state_d, flash_on_d);
    end
  end

  assign NS_light    = ns_q;
  assign EW_light    = ew_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Scoreboard bench for traffic_light_ctrl_p: the stimulus process pushes the
// hand-derived expected phase for every cycle, per-DUT monitors pop and compare.
module tb_traffic_light_ctrl_p;

  localparam int T_NSG  = 0;
  localparam int T_NSY  = 1;
  localparam int T_AR1  = 2;
  localparam int T_EWG  = 3;
  localparam int T_EWY  = 4;
  localparam int T_AR2  = 5;
  localparam int T_WALK = 6;
  localparam int T_FON  = 7;
  localparam int T_FOFF = 8;

  typedef struct {
    int   tag;
    logic pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ped_req;
  logic flash_mode;

  logic [2:0] ns_a, ew_a, st_a;
  logic       walk_a, pend_a;
  logic [2:0] ns_b, ew_b, st_b;
  logic       walk_b, pend_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int    checks = 0;
  int    errors = 0;
  string scen   = "init";

  always #5 clk = ~clk;

  traffic_light_ctrl_p dut_a (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .NS_light(ns_a), .EW_light(ew_a), .walk(walk_a),
    .ped_pending(pend_a), .state_o(st_a)
  );

  traffic_light_ctrl_p #(.TICK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .NS_light(ns_b), .EW_light(ew_b), .walk(walk_b),
    .ped_pending(pend_b), .state_o(st_b)
  );

  // Hand table of {NS, EW, walk, state} for each expected phase tag.
  function automatic logic [9:0] tag_table(input int tag);
    case (tag)
      T_NSG:   return {3'b001, 3'b100, 1'b0, 3'd0};
      T_NSY:   return {3'b010, 3'b100, 1'b0, 3'd1};
      T_AR1:   return {3'b100, 3'b100, 1'b0, 3'd2};
      T_EWG:   return {3'b100, 3'b001, 1'b0, 3'd3};
      T_EWY:   return {3'b100, 3'b010, 1'b0, 3'd4};
      T_AR2:   return {3'b100, 3'b100, 1'b0, 3'd5};
      T_WALK:  return {3'b100, 3'b100, 1'b1, 3'd6};
      T_FON:   return {3'b010, 3'b010, 1'b0, 3'd7};
      default: return {3'b000, 3'b000, 1'b0, 3'd7};
    endcase
  endfunction

  // Compare one DUT's outputs against a popped expectation.
  task automatic checkOutput(input int sel, input exp_t e);
    logic [10:0] want, got;
    logic [9:0]  t;
    t    = tag_table(e.tag);
    want = {t[9:3], e.pend, t[2:0]};
    if (sel == 0) got = {ns_a, ew_a, walk_a, pend_a, st_a};
    else          got = {ns_b, ew_b, walk_b, pend_b, st_b};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d tag=%0d t=%0t got {ns,ew,walk,pend,st}=%b required=%b",
               scen, sel, e.tag, $time, got, want);
    end
  endtask

  // Monitor for the default-timing DUT.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      e_a = q_a.pop_front();
      checkOutput(0, e_a);
    end
  end

  // Monitor for the TICK_DIV=4 DUT.
  always @(negedge clk) begin
    if (q_b.size() > 0) begin
      e_b = q_b.pop_front();
      checkOutput(1, e_b);
    end
  end

  task automatic applyStimulus(input logic ped, input logic flash);
    ped_req    = ped;
    flash_mode = flash;
  endtask

  // Push n cycles of one expected phase and step that many clocks.
  task automatic seg(input int sel, input int tag, input int n, input logic pend);
    exp_t e;
    e.tag  = tag;
    e.pend = pend;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Reset asserted mid-cycle must show reset values at once; released after 2 cycles.
  task automatic do_reset(input int sel);
    reset = 1'b0;
    seg(sel, T_NSG, 2, 1'b0);
    reset = 1'b1;
  endtask

  task automatic one_period(input logic pend);
    seg(0, T_NSG, 50, pend);
    seg(0, T_NSY, 10, pend);
    seg(0, T_AR1, 2, pend);
    seg(0, T_EWG, 50, pend);
    seg(0, T_EWY, 10, pend);
    seg(0, T_AR2, 2, pend);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #1;

    scen = "cycle";
    do_reset(0);
    one_period(1'b0);
    one_period(1'b0);
    seg(0, T_NSG, 3, 1'b0);

    scen = "ped";
    do_reset(0);
    seg(0, T_NSG, 5, 1'b0);
    applyStimulus(1'b1, 1'b0);
    seg(0, T_NSG, 1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_NSG, 44, 1'b1);
    seg(0, T_NSY, 10, 1'b1);
    seg(0, T_AR1, 2, 1'b1);
    seg(0, T_EWG, 50, 1'b1);
    seg(0, T_EWY, 10, 1'b1);
    seg(0, T_AR2, 2, 1'b1);
    seg(0, T_WALK, 6, 1'b0);
    applyStimulus(1'b1, 1'b0);
    seg(0, T_WALK, 6, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_WALK, 8, 1'b0);
    seg(0, T_NSG, 50, 1'b0);
    seg(0, T_NSY, 10, 1'b0);
    seg(0, T_AR1, 2, 1'b0);
    seg(0, T_EWG, 50, 1'b0);
    seg(0, T_EWY, 10, 1'b0);
    seg(0, T_AR2, 1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    seg(0, T_AR2, 1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_NSG, 5, 1'b1);

    scen = "flash";
    do_reset(0);
    seg(0, T_NSG, 10, 1'b0);
    applyStimulus(1'b0, 1'b1);
    seg(0, T_NSG, 40, 1'b0);
    seg(0, T_NSY, 10, 1'b0);
    seg(0, T_AR1, 2, 1'b0);
    seg(0, T_FON, 5, 1'b0);
    seg(0, T_FOFF, 5, 1'b0);
    seg(0, T_FON, 2, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_FON, 3, 1'b0);
    seg(0, T_FOFF, 5, 1'b0);
    seg(0, T_AR2, 2, 1'b0);
    seg(0, T_NSG, 5, 1'b0);

    scen = "flash_ped";
    do_reset(0);
    applyStimulus(1'b1, 1'b0);
    seg(0, T_NSG, 1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_NSG, 49, 1'b1);
    seg(0, T_NSY, 10, 1'b1);
    seg(0, T_AR1, 2, 1'b1);
    seg(0, T_EWG, 20, 1'b1);
    applyStimulus(1'b0, 1'b1);
    seg(0, T_EWG, 30, 1'b1);
    seg(0, T_EWY, 10, 1'b1);
    seg(0, T_AR2, 2, 1'b1);
    seg(0, T_FON, 5, 1'b1);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_FOFF, 5, 1'b1);
    seg(0, T_AR2, 2, 1'b1);
    seg(0, T_WALK, 20, 1'b0);
    seg(0, T_NSG, 3, 1'b0);

    scen = "reset_mid";
    do_reset(0);
    applyStimulus(1'b1, 1'b0);
    seg(0, T_NSG, 1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    seg(0, T_NSG, 49, 1'b1);
    seg(0, T_NSY, 10, 1'b1);
    seg(0, T_AR1, 2, 1'b1);
    seg(0, T_EWG, 20, 1'b1);
    do_reset(0);
    applyStimulus(1'b0, 1'b1);
    seg(0, T_NSG, 50, 1'b0);
    seg(0, T_NSY, 10, 1'b0);
    seg(0, T_AR1, 2, 1'b0);
    seg(0, T_FON, 5, 1'b0);
    seg(0, T_FOFF, 2, 1'b0);
    applyStimulus(1'b0, 1'b0);
    do_reset(0);
    seg(0, T_NSG, 50, 1'b0);
    seg(0, T_NSY, 2, 1'b0);

    scen = "tickdiv4";
    do_reset(1);
    seg(1, T_NSG, 200, 1'b0);
    seg(1, T_NSY, 40, 1'b0);
    seg(1, T_AR1, 8, 1'b0);
    seg(1, T_EWG, 4, 1'b0);

    repeat (2) @(posedge clk);
    scen = "drain";
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending got=%0d/%0d required=0/0", q_a.size(), q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
